// File: rtl/fifo_parity_tx_pkg.sv
// fifo_parity_tx shared types: bandwidth modes, pacing states, parity helper.
// Imported by the RTL and by the bench; no ports.
package fifo_tb_pkg;

  typedef enum bit [1:0] {
    BW_000 = 2'b00,
    BW_050 = 2'b01,
    BW_100 = 2'b10
  } bw_mode_e;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE = 2'd0;
  localparam tx_state_t ST_SEND = 2'd1;
  localparam tx_state_t ST_GAP  = 2'd2;

  // Zero-extension does not change an XOR reduction, so one
  // 64-bit helper serves every DATA_W up to 64.
  function automatic logic calc_parity(
    input logic [63:0] d,
    input logic        odd
  );
    return (^d) ^ odd;
  endfunction

  // 2'b11 has no enum member and runs at full rate.
  function automatic bw_mode_e norm_mode(input logic [1:0] m);
    case (m)
      2'b00:   return BW_000;
      2'b01:   return BW_050;
      default: return BW_100;
    endcase
  endfunction

endpackage

// File: rtl/fifo_parity_tx_if.sv
// fifo_parity_tx handshake bundle: upstream valid/ready and downstream
// valid/grant with data+parity. slave = transmitter, master = its peers.
interface fifo_parity_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic [DATA_W-1:0] data_out;
  logic              parity_out;
  logic              valid_out;
  logic              grant_in;

  modport slave (
    input  data_in, valid_in, grant_in,
    output ready_out, data_out, parity_out, valid_out
  );

  modport master (
    output data_in, valid_in, grant_in,
    input  ready_out, data_out, parity_out, valid_out
  );
endinterface

// File: rtl/fifo_parity_tx_queue.sv
// Two-entry {data,parity} queue with registered occupancy and ready.
// Ports: push/pop strobes, write word, head word, ready_out, occ_out.
module fifo_parity_tx_queue #(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              push_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              wpar_in,
  input  logic              pop_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] hdata_out,
  output logic              hpar_out,
  output logic [1:0]        occ_out
);
  logic [DATA_W-1:0] data_q [2];
  logic [1:0]        par_q;
  logic              wr_q;
  logic              rd_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic              rdy_q;

  assign occ_d = occ_q + 2'(push_in) - 2'(pop_in);

  // ready is a register of next occupancy, so a pop at
  // occupancy 2 frees the slot only from the next cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      par_q     <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      occ_q     <= 2'd0;
      rdy_q     <= 1'b0;
    end else begin
      if (push_in) begin
        data_q[wr_q] <= wdata_in;
        par_q[wr_q]  <= wpar_in;
        wr_q         <= ~wr_q;
      end
      if (pop_in) begin
        rd_q <= ~rd_q;
      end
      occ_q <= occ_d;
      rdy_q <= (occ_d != 2'd2);
    end
  end

  assign ready_out = rdy_q;
  assign occ_out   = occ_q;
  assign hdata_out = (occ_q != 2'd0) ? data_q[rd_q] : '0;
  assign hpar_out  = (occ_q != 2'd0) ? par_q[rd_q] : 1'b0;

endmodule

// File: rtl/fifo_parity_tx.sv
// Parity-generating transmitter: queues words and paces them out by bw mode.
// Ports: clk/rst, bw_mode_in, tx_count_out, bus (slave); inject_err_in with FIFO_PARITY_ERR_INJECT_EN.
module fifo_parity_tx
  import fifo_tb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
`ifdef FIFO_PARITY_ERR_INJECT_EN
  input  logic             inject_err_in,
`endif
  input  logic [1:0]       bw_mode_in,
  output logic [CNT_W-1:0] tx_count_out,
  fifo_parity_tx_if.slave  bus
);
  tx_state_t         st_q, st_d;
  bw_mode_e          mode_q, mode_d, mode_new;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop, wpar, q_ready, err;
  logic [1:0]        occ, occ_nx;
  logic [DATA_W-1:0] hdata;
  logic              hpar;

`ifdef FIFO_PARITY_ERR_INJECT_EN
  assign err = inject_err_in;
`else
  assign err = 1'b0;
`endif

  assign push   = bus.valid_in & q_ready;
  assign pop    = (st_q == ST_SEND) & bus.grant_in;
  assign occ_nx = occ + 2'(push) - 2'(pop);
  assign wpar   = calc_parity(64'(bus.data_in), ODD_PARITY != 0) ^ err;

  fifo_parity_tx_queue #(.DATA_W(DATA_W)) u_queue (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push_in  (push),
    .wdata_in (bus.data_in),
    .wpar_in  (wpar),
    .pop_in   (pop),
    .ready_out(q_ready),
    .hdata_out(hdata),
    .hpar_out (hpar),
    .occ_out  (occ)
  );

  // Mode only changes where valid_out is low or a transfer
  // completes, so a raised valid_out is never withdrawn.
  always_comb begin
    st_d     = st_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    mode_new = norm_mode(bw_mode_in);
    case (st_q)
      ST_IDLE: begin
        mode_d = mode_new;
        if ((occ != 2'd0 || push) && mode_new != BW_000)
          st_d = ST_SEND;
      end
      ST_SEND: begin
        if (bus.grant_in) begin
          mode_d = mode_new;
          cnt_d  = cnt_q + CNT_W'(1);
          if (occ_nx == 2'd0)
            st_d = ST_IDLE;
          else if (mode_q == BW_050)
            st_d = ST_GAP;
          else if (mode_new == BW_000)
            st_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        mode_d = mode_new;
        if ((occ != 2'd0 || push) && mode_new != BW_000)
          st_d = ST_SEND;
        else
          st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      st_q   <= ST_IDLE;
      mode_q <= BW_100;
      cnt_q  <= '0;
    end else begin
      st_q   <= st_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.ready_out  = q_ready;
  assign bus.valid_out  = (st_q == ST_SEND);
  assign bus.data_out   = hdata;
  assign bus.parity_out = hpar;
  assign tx_count_out   = cnt_q;

endmodule

// File: tb/tb_fifo_parity_tx.sv
// Directed bench for fifo_parity_tx: even and odd instances, all modes.
// Checks at the falling edge; inputs change right after each check.
module tb_fifo_parity_tx;
  import fifo_tb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        inj;
  logic [15:0] cnt0, cnt1;
  int          errs = 0;
  int          checks = 0;

  fifo_parity_tx_if #(.DATA_W(8)) bus0();
  fifo_parity_tx_if #(.DATA_W(8)) bus1();

  always #5 clk = ~clk;

  fifo_parity_tx #(.DATA_W(8), .ODD_PARITY(0), .CNT_W(16)) u0 (
    .clk_in      (clk),
    .rst_in      (rst),
`ifdef FIFO_PARITY_ERR_INJECT_EN
    .inject_err_in(inj),
`endif
    .bw_mode_in  (mode),
    .tx_count_out(cnt0),
    .bus         (bus0)
  );

  fifo_parity_tx #(.DATA_W(8), .ODD_PARITY(1), .CNT_W(16)) u1 (
    .clk_in      (clk),
    .rst_in      (rst),
`ifdef FIFO_PARITY_ERR_INJECT_EN
    .inject_err_in(1'b0),
`endif
    .bw_mode_in  (mode),
    .tx_count_out(cnt1),
    .bus         (bus1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] w [4];
    logic       wp [4];
    logic       pat [8];
    int         idx, s;
    logic       hs;

    rst = 1'b1;
    mode = 2'b10;
    inj = 1'b0;
    bus0.valid_in = 1'b0; bus0.data_in = '0; bus0.grant_in = 1'b0;
    bus1.valid_in = 1'b0; bus1.data_in = '0; bus1.grant_in = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_ready", bus0.ready_out, 0);
    chk("rst_valid", bus0.valid_out, 0);
    chk("rst_data", bus0.data_out, 0);
    chk("rst_par", bus0.parity_out, 0);
    chk("rst_cnt", cnt0, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", bus0.ready_out, 1);
    chk("post_rst_valid", bus0.valid_out, 0);

    // BW_100, back-to-back words with grant held high.
    bus0.grant_in = 1'b1;
    bus0.valid_in = 1'b1; bus0.data_in = 8'h00;
    tick();
    chk("b100_v0", bus0.valid_out, 1);
    chk("b100_d0", bus0.data_out, 8'h00);
    chk("b100_p0", bus0.parity_out, 0);
    bus0.data_in = 8'hA5;
    tick();
    chk("b100_v1", bus0.valid_out, 1);
    chk("b100_d1", bus0.data_out, 8'hA5);
    chk("b100_p1", bus0.parity_out, 0);
    bus0.data_in = 8'hFF;
    tick();
    chk("b100_d2", bus0.data_out, 8'hFF);
    chk("b100_p2", bus0.parity_out, 0);
    bus0.valid_in = 1'b0;
    tick();
    chk("b100_idle_v", bus0.valid_out, 0);
    chk("b100_idle_d", bus0.data_out, 0);
    chk("b100_cnt", cnt0, 3);

    // Odd parity instance.
    bus1.grant_in = 1'b1;
    bus1.valid_in = 1'b1; bus1.data_in = 8'h01;
    tick();
    chk("odd_d01", bus1.data_out, 8'h01);
    chk("odd_p01", bus1.parity_out, 0);
    bus1.data_in = 8'h03;
    tick();
    chk("odd_d03", bus1.data_out, 8'h03);
    chk("odd_p03", bus1.parity_out, 1);
    bus1.valid_in = 1'b0;
    tick();
    chk("odd_cnt", cnt1, 2);

    // BW_050 with a continuously willing producer.
    w[0] = 8'h01; w[1] = 8'h22; w[2] = 8'h07; w[3] = 8'h44;
    wp[0] = 1'b1; wp[1] = 1'b0; wp[2] = 1'b1; wp[3] = 1'b0;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0;
    pat[4] = 1; pat[5] = 0; pat[6] = 1; pat[7] = 0;
    mode = 2'b01;
    idx = 0; s = 0;
    bus0.valid_in = 1'b1; bus0.data_in = w[0];
    for (int k = 0; k < 8; k++) begin
      hs = bus0.valid_in & bus0.ready_out;
      tick();
      if (hs) idx++;
      if (idx >= 4) bus0.valid_in = 1'b0;
      else bus0.data_in = w[idx];
      chk($sformatf("b050_v%0d", k), bus0.valid_out, pat[k]);
      if (pat[k] && s < 4) begin
        chk($sformatf("b050_d%0d", s), bus0.data_out, w[s]);
        chk($sformatf("b050_p%0d", s), bus0.parity_out, wp[s]);
        s++;
      end
    end
    chk("b050_cnt", cnt0, 7);

    // BW_000 holds two words and back-pressures the third.
    mode = 2'b00;
    bus0.valid_in = 1'b1; bus0.data_in = 8'hC3;
    tick();
    chk("b000_v0", bus0.valid_out, 0);
    chk("b000_r0", bus0.ready_out, 1);
    bus0.data_in = 8'h5B;
    tick();
    bus0.data_in = 8'h99;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("b000_r%0d", k + 1), bus0.ready_out, 0);
      chk($sformatf("b000_v%0d", k + 1), bus0.valid_out, 0);
      chk($sformatf("b000_h%0d", k + 1), bus0.data_out, 8'hC3);
      tick();
    end
    mode = 2'b10;
    bus0.valid_in = 1'b0;
    tick();
    chk("drain_v0", bus0.valid_out, 1);
    chk("drain_d0", bus0.data_out, 8'hC3);
    chk("drain_p0", bus0.parity_out, 0);
    tick();
    chk("drain_v1", bus0.valid_out, 1);
    chk("drain_d1", bus0.data_out, 8'h5B);
    chk("drain_p1", bus0.parity_out, 1);
    chk("drain_r1", bus0.ready_out, 1);
    tick();
    chk("drain_v2", bus0.valid_out, 0);
    chk("drain_r2", bus0.ready_out, 1);
    chk("drain_cnt", cnt0, 9);

    // Stall with grant low, then reset mid-stall.
    bus0.grant_in = 1'b0;
    bus0.valid_in = 1'b1; bus0.data_in = 8'h3D;
    tick();
    bus0.valid_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_v%0d", k), bus0.valid_out, 1);
      chk($sformatf("stall_d%0d", k), bus0.data_out, 8'h3D);
      chk($sformatf("stall_p%0d", k), bus0.parity_out, 1);
      tick();
    end
    chk("stall_cnt", cnt0, 9);
    rst = 1'b1;
    tick();
    chk("mrst_v", bus0.valid_out, 0);
    chk("mrst_cnt", cnt0, 0);
    chk("mrst_d", bus0.data_out, 0);
    chk("mrst_p", bus0.parity_out, 0);
    rst = 1'b0;
    bus0.grant_in = 1'b1;
    tick();
    chk("mrst_r", bus0.ready_out, 1);
    tick();
    chk("mrst_empty_v", bus0.valid_out, 0);
    chk("mrst_empty_cnt", cnt0, 0);

    // Encoding 2'b11 runs at full rate.
    mode = 2'b11;
    bus0.valid_in = 1'b1; bus0.data_in = 8'h80;
    tick();
    bus0.data_in = 8'h81;
    chk("b11_v0", bus0.valid_out, 1);
    chk("b11_p0", bus0.parity_out, 1);
    tick();
    bus0.valid_in = 1'b0;
    chk("b11_v1", bus0.valid_out, 1);
    chk("b11_d1", bus0.data_out, 8'h81);
    chk("b11_p1", bus0.parity_out, 0);
    tick();
    chk("b11_v2", bus0.valid_out, 0);
    chk("b11_cnt", cnt0, 2);

`ifdef FIFO_PARITY_ERR_INJECT_EN
    mode = 2'b10;
    inj = 1'b1;
    bus0.valid_in = 1'b1; bus0.data_in = 8'h0F;
    tick();
    inj = 1'b0;
    chk("inj_d", bus0.data_out, 8'h0F);
    chk("inj_p", bus0.parity_out, 1);
    tick();
    bus0.valid_in = 1'b0;
    chk("noinj_d", bus0.data_out, 8'h0F);
    chk("noinj_p", bus0.parity_out, 0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
